// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative radix-2 restoring divider, WA-bit dividend by WB-bit divisor
module seq_divider #(
    parameter int WB = 8,
    parameter int WA = 2 * WB
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [WA-1:0] A,
    input  logic [WB-1:0] B,
    output logic [WA-1:0] q,
    output logic [WB-1:0] r,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero
);

    localparam int CW = $clog2(WA);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [WA-1:0] dvd;
    logic [WB-1:0] dvs;
    logic [WB-1:0] rem;
    logic [CW-1:0] count;

    logic [WB:0]   shifted;
    logic [WB:0]   trial;
    logic          qbit;
    logic [WB-1:0] rem_next;
    logic [WA-1:0] dvd_next;

    // The held remainder is always below the divisor, so only the shifted
    // value and the trial subtraction need the extra bit.
    always_comb begin
        shifted  = {rem, dvd[WA-1]};
        trial    = shifted - {1'b0, dvs};
        qbit     = ~trial[WB];
        rem_next = qbit ? trial[WB-1:0] : shifted[WB-1:0];
        dvd_next = {dvd[WA-2:0], qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            count       <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dvd         <= A;
                        dvs         <= B;
                        rem         <= '0;
                        div_by_zero <= 1'b0;
                        state       <= S_RUN;
                        // A zero divisor takes a single RUN step so its done
                        // pulse lands one cycle after acceptance.
                        count       <= (B == '0) ? CW'(WA - 1) : '0;
                    end
                end
                S_RUN: begin
                    dvd   <= dvd_next;
                    rem   <= rem_next;
                    count <= count + 1'b1;
                    if (count == CW'(WA - 1)) begin
                        state <= S_DONE;
                        if (dvs == '0) begin
                            q           <= '1;
                            r           <= dvd[WB-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            q <= dvd_next;
                            r <= rem_next;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic model
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [7:0]  B;
    logic [15:0] q;
    logic [7:0]  r;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(.WB(8), .WA(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .q(q), .r(r), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: result from plain division, timing as a countdown of cycles.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [15:0] m_q = '0, p_q = '0, p_a = '0;
    logic [7:0]  m_r = '0, p_r = '0, p_b = '0;
    logic        m_dz = 1'b0, p_dz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 1'b0; m_q = '0; m_r = '0; m_dz = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_q = p_q; m_r = p_r; m_dz = p_dz; m_done = 1'b1;
            end
        end else if (start) begin
            p_a = A; p_b = B; m_dz = 1'b0;
            if (B == 8'd0) begin
                p_q = 16'hFFFF; p_r = A[7:0]; p_dz = 1'b1; m_left = 1;
            end else begin
                p_q = A / {8'd0, B}; p_r = 8'(A % {8'd0, B}); p_dz = 1'b0; m_left = 16;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("q", {16'd0, q}, {16'd0, m_q});
        chk("r", {24'd0, r}, {24'd0, m_r});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dz});
        if (done && !div_by_zero && p_b != 8'd0) begin
            chk("q*B+r==A", 32'(q) * 32'(p_b) + 32'(r), 32'(p_a));
            chk("r<B", {31'd0, r < p_b}, 32'd1);
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                          input logic [7:0] er, input logic edz, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        start = 1'b1; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("lit_q", {16'd0, q}, {16'd0, eq});
        chk("lit_r", {24'd0, r}, {24'd0, er});
        chk("lit_dz", {31'd0, div_by_zero}, {31'd0, edz});
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", {16'd0, q}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        run_op(16'd1000, 8'd7,   16'd142,   8'd6, 1'b0, 16);
        run_op(16'hFFFF, 8'hFF,  16'h0101,  8'd0, 1'b0, 16);
        run_op(16'hFFFF, 8'h01,  16'hFFFF,  8'd0, 1'b0, 16);
        run_op(16'd3,    8'd200, 16'd0,     8'd3, 1'b0, 16);
        run_op(16'h8000, 8'h80,  16'h0100,  8'd0, 1'b0, 16);
        run_op(16'd5,    8'd0,   16'hFFFF,  8'h05, 1'b1, 1);
        run_op(16'd10,   8'd3,   16'd3,     8'd1, 1'b0, 16);

        // Re-start during RUN is ignored.
        @(posedge clk); #1;
        start = 1'b1; A = 16'd1000; B = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; A = 16'd50; B = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("restart_ignored_q", {16'd0, q}, 32'd142);
        chk("restart_ignored_r", {24'd0, r}, 32'd6);

        // Reset at cycle 8 of RUN discards the division.
        start = 1'b1; A = 16'd40000; B = 8'd13;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_q", {16'd0, q}, 32'd0);
        chk("midrst_r", {24'd0, r}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(16'd40000, 8'd13, 16'd3076, 8'd12, 1'b0, 16);

        // Back-to-back: start held high while operands change every cycle.
        start = 1'b1;
        for (int i = 0; i < 300; i++) begin
            A = $urandom;
            B = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        for (int i = 0; i < 1200; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            if (rb == 8'd0)
                run_op(ra, rb, 16'hFFFF, ra[7:0], 1'b1, 1);
            else
                run_op(ra, rb, ra / {8'd0, rb}, 8'(ra % {8'd0, rb}), 1'b0, 16);
        end

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
